// File: rtl/dsm2_dac_echip65_pkg.sv
// Shared constants for the 2nd-order sigma-delta DAC modulator: debug monitor
// select codes and the bit layout of the flag word shown on the monitor.
package dsm2_dac_echip65_pkg;

  localparam int MON_WIDTH     = 25;
  localparam int MON_SEL_WIDTH = 4;

  localparam logic [MON_SEL_WIDTH-1:0] DSM_MON_CUR   = 4'd0;
  localparam logic [MON_SEL_WIDTH-1:0] DSM_MON_INT1  = 4'd1;
  localparam logic [MON_SEL_WIDTH-1:0] DSM_MON_INT2  = 4'd2;
  localparam logic [MON_SEL_WIDTH-1:0] DSM_MON_CNT   = 4'd3;
  localparam logic [MON_SEL_WIDTH-1:0] DSM_MON_FLAGS = 4'd4;
  localparam logic [MON_SEL_WIDTH-1:0] DSM_MON_NEXT  = 4'd5;

  // Flag word as seen on DSM_MON_FLAGS: {full, underrun, overload, dout}
  localparam int FLAG_WIDTH    = 4;
  localparam int FLAG_DOUT     = 0;
  localparam int FLAG_OVERLOAD = 1;
  localparam int FLAG_UNDERRUN = 2;
  localparam int FLAG_FULL     = 3;

endpackage

// File: rtl/dsm2_dac_echip65_if.sv
// Sample stream into the sigma-delta modulator: signed PCM word with a
// valid/ready handshake at the decimated rate.
interface dsm2_dac_echip65_if #(
  parameter int IN_WIDTH = 16
);
  logic signed [IN_WIDTH-1:0] sample_in;
  logic                       sample_valid;
  logic                       sample_ready;

  modport master (output sample_in, output sample_valid, input sample_ready);
  modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/dsm2_sat_acc.sv
// Saturating signed accumulator: acc' = sat(acc + add_val - sub_val).
// The next value is exposed combinationally so a second stage can chain off it.
module dsm2_sat_acc #(
  parameter int ACC_WIDTH = 24
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic signed [ACC_WIDTH-1:0] add_val,
  input  logic signed [ACC_WIDTH-1:0] sub_val,
  output logic signed [ACC_WIDTH-1:0] acc_q,
  output logic signed [ACC_WIDTH-1:0] acc_d,
  output logic                        sat
);

  // Two guard bits: acc + add - sub can reach almost 3x full scale of the
  // accumulator when add_val is itself a saturated integrator.
  localparam int SUM_WIDTH = ACC_WIDTH + 2;
  localparam logic signed [SUM_WIDTH-1:0] ACC_MAX =
    (SUM_WIDTH'(1) <<< (ACC_WIDTH - 1)) - SUM_WIDTH'(1);
  localparam logic signed [SUM_WIDTH-1:0] ACC_MIN =
    -(SUM_WIDTH'(1) <<< (ACC_WIDTH - 1));

  logic signed [SUM_WIDTH-1:0] sum;

  assign sum = SUM_WIDTH'(acc_q) + SUM_WIDTH'(add_val) - SUM_WIDTH'(sub_val);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the ifs leaves it unassigned and a latch can't be inferred.
    acc_d = sum[ACC_WIDTH-1:0];
    sat   = 1'b0;
    if (sum > ACC_MAX) begin
      acc_d = ACC_MAX[ACC_WIDTH-1:0];
      sat   = 1'b1;
    end else if (sum < ACC_MIN) begin
      acc_d = ACC_MIN[ACC_WIDTH-1:0];
      sat   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: registers take non-blocking assignments so every flop samples the
    // pre-edge values, independent of the order the always blocks run in.
    if (!reset_n) acc_q <= '0;
    else          acc_q <= acc_d;
  end

endmodule

// File: rtl/dsm2_dac_echip65.sv
// Second-order sigma-delta modulator for the on-chip 1-bit DAC: buffers one PCM
// sample, holds it for OSR clocks and emits a pulse-density bitstream.
module dsm2_dac_echip65
  import dsm2_dac_echip65_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int ACC_WIDTH = 24,
  parameter int OSR       = 256
) (
  input  logic                     clk,
  input  logic                     reset_n,
  dsm2_dac_echip65_if.slave        smp,
  output logic                     dout,
  output logic                     overload,
  output logic                     underrun,
  output logic [MON_WIDTH-1:0]     digital_monitor,
  input  logic [MON_SEL_WIDTH-1:0] digital_monitor_sel
);

  localparam int CNT_WIDTH = $clog2(OSR);
  localparam logic [CNT_WIDTH-1:0]        CNT_LAST = CNT_WIDTH'(OSR - 1);
  localparam logic signed [ACC_WIDTH-1:0] FS_POS   = ACC_WIDTH'(1) <<< (IN_WIDTH - 1);
  localparam logic signed [ACC_WIDTH-1:0] FS_NEG   = -FS_POS;

  logic signed [IN_WIDTH-1:0]  next_sample;
  logic signed [IN_WIDTH-1:0]  cur_sample;
  logic                        full;
  logic                        full_d;
  logic                        ready_q;
  logic [CNT_WIDTH-1:0]        cnt;
  logic                        wrap;
  logic                        accept;
  logic signed [ACC_WIDTH-1:0] fb;
  logic signed [ACC_WIDTH-1:0] cur_ext;
  logic signed [ACC_WIDTH-1:0] int1_q;
  logic signed [ACC_WIDTH-1:0] int1_d;
  logic signed [ACC_WIDTH-1:0] int2_q;
  logic signed [ACC_WIDTH-1:0] int2_d;
  logic                        sat1;
  logic                        sat2;
  logic [FLAG_WIDTH-1:0]       flags;
  logic [MON_WIDTH-1:0]        mon_d;

  assign smp.sample_ready = ready_q;
  assign accept           = smp.sample_valid & ready_q;
  assign wrap             = (cnt == CNT_LAST);

  // A buffered sample leaves at the wrap; a new one can only arrive when empty.
  always_comb begin
    full_d = full;
    if (wrap && full) full_d = 1'b0;
    if (accept)       full_d = 1'b1;
  end

  // Feedback follows the bit currently driven onto the DAC.
  assign fb      = dout ? FS_POS : FS_NEG;
  assign cur_ext = ACC_WIDTH'(cur_sample);

  dsm2_sat_acc #(.ACC_WIDTH(ACC_WIDTH)) u_int1 (
    .clk     (clk),
    .reset_n (reset_n),
    .add_val (cur_ext),
    .sub_val (fb),
    .acc_q   (int1_q),
    .acc_d   (int1_d),
    .sat     (sat1)
  );

  dsm2_sat_acc #(.ACC_WIDTH(ACC_WIDTH)) u_int2 (
    .clk     (clk),
    .reset_n (reset_n),
    .add_val (int1_d),
    .sub_val (fb),
    .acc_q   (int2_q),
    .acc_d   (int2_d),
    .sat     (sat2)
  );

  always_comb begin
    flags                = '0;
    flags[FLAG_FULL]     = full;
    flags[FLAG_UNDERRUN] = underrun;
    flags[FLAG_OVERLOAD] = overload;
    flags[FLAG_DOUT]     = dout;
  end

  always_comb begin
    mon_d = '0;
    case (digital_monitor_sel)
      DSM_MON_CUR:   mon_d = MON_WIDTH'(cur_sample);
      DSM_MON_INT1:  mon_d = MON_WIDTH'(int1_q);
      DSM_MON_INT2:  mon_d = MON_WIDTH'(int2_q);
      DSM_MON_CNT:   mon_d = MON_WIDTH'(cnt);
      DSM_MON_FLAGS: mon_d = MON_WIDTH'(flags);
      DSM_MON_NEXT:  mon_d = MON_WIDTH'(next_sample);
      default:       mon_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      next_sample     <= '0;
      cur_sample      <= '0;
      full            <= 1'b0;
      ready_q         <= 1'b0;
      cnt             <= '0;
      dout            <= 1'b0;
      overload        <= 1'b0;
      underrun        <= 1'b0;
      digital_monitor <= '0;
    end else begin
      cnt     <= cnt + CNT_WIDTH'(1);
      full    <= full_d;
      ready_q <= ~full_d;
      if (accept) next_sample <= smp.sample_in;
      // An empty buffer at the wrap keeps playing the old sample.
      if (wrap) begin
        if (full) cur_sample <= next_sample;
        else      underrun   <= 1'b1;
      end
      dout            <= ~int2_d[ACC_WIDTH-1];
      overload        <= overload | sat1 | sat2;
      digital_monitor <= mon_d;
    end
  end

endmodule
